// File: rtl/rc4_core_scheduler_if.sv
// Control/status and per-core launch/result lines between the RC4 key scheduler and its cracking cores.
interface rc4_core_scheduler_if #(
    parameter int NUM_CORES = 4,
    parameter int KEY_WIDTH = 24
);
    logic                           start;
    logic                           busy;
    logic                           found;
    logic                           not_found;
    logic [KEY_WIDTH-1:0]           found_key;
    logic [KEY_WIDTH:0]             keys_tried;
    logic [NUM_CORES-1:0]           core_start;
    logic [NUM_CORES*KEY_WIDTH-1:0] core_key;
    logic [NUM_CORES-1:0]           core_finish;
    logic [NUM_CORES-1:0]           core_valid;

    modport master (
        input  start, core_finish, core_valid,
        output busy, found, not_found, found_key, keys_tried, core_start, core_key
    );

    modport slave (
        output start, core_finish, core_valid,
        input  busy, found, not_found, found_key, keys_tried, core_start, core_key
    );
endinterface

// File: rtl/rc4_core_scheduler.sv
// Hands ascending RC4 keys to NUM_CORES cracking cores, collects pass/fail results and
// reports the first key whose decryption is all valid ASCII.
module rc4_core_scheduler #(
    parameter int                   NUM_CORES = 4,
    parameter int                   KEY_WIDTH = 24,
    parameter logic [KEY_WIDTH-1:0] KEY_MAX   = 24'h3FFFFF
) (
    input  logic                 clk,
    input  logic                 reset_n,
    rc4_core_scheduler_if.master bus
);
    localparam int               CNT_W    = KEY_WIDTH + 1;
    localparam logic [CNT_W-1:0] KEY_LAST = {1'b0, KEY_MAX};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{KEY_WIDTH{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_RUN        = 3'd1,
        S_DRAIN      = 3'd2,
        S_DONE_FOUND = 3'd3,
        S_DONE_FAIL  = 3'd4
    } state_t;

    state_t                         state_q, state_d;
    logic [CNT_W-1:0]               next_key_q, next_key_d;
    logic [NUM_CORES-1:0]           core_busy_q, core_busy_d;
    logic [NUM_CORES-1:0]           core_start_q, core_start_d;
    logic [NUM_CORES*KEY_WIDTH-1:0] core_key_q, core_key_d;
    logic [KEY_WIDTH-1:0]           found_key_q, found_key_d;
    logic [CNT_W-1:0]               keys_tried_q, keys_tried_d;
    logic                           busy_q, busy_d;
    logic                           found_q, found_d;
    logic                           not_found_q, not_found_d;
    logic                           hit_s;
    logic                           disp_s;

    // Next-state, dispatch and result collection.
    always_comb begin
        state_d      = state_q;
        next_key_d   = next_key_q;
        core_busy_d  = core_busy_q;
        core_start_d = {NUM_CORES{1'b0}};
        core_key_d   = core_key_q;
        found_key_d  = found_key_q;
        keys_tried_d = keys_tried_q;
        hit_s        = 1'b0;
        disp_s       = 1'b0;

        case (state_q)
            S_IDLE, S_DONE_FOUND, S_DONE_FAIL: begin
                if (bus.start) begin
                    state_d      = S_RUN;
                    found_key_d  = {KEY_WIDTH{1'b0}};
                    keys_tried_d = {CNT_W{1'b0}};
                    next_key_d   = {CNT_W{1'b0}};
                end else begin
                    state_d = state_q;
                end
            end
            S_RUN, S_DRAIN: begin
                // Finishes from idle cores are stale or spurious and carry no key.
                for (int i = 0; i < NUM_CORES; i++) begin
                    if (bus.core_finish[i] && core_busy_q[i]) begin
                        core_busy_d[i] = 1'b0;
                        keys_tried_d   = keys_tried_d + CNT_ONE;
                        if ((state_q == S_RUN) && bus.core_valid[i] && !hit_s) begin
                            hit_s       = 1'b1;
                            found_key_d = core_key_q[i*KEY_WIDTH +: KEY_WIDTH];
                        end else begin
                            hit_s = hit_s;
                        end
                    end else begin
                        core_busy_d[i] = core_busy_d[i];
                    end
                end

                if (state_q == S_DRAIN) begin
                    state_d = (core_busy_q == {NUM_CORES{1'b0}}) ? S_DONE_FOUND : S_DRAIN;
                end else if (hit_s) begin
                    state_d = S_DRAIN;
                end else if (next_key_q > KEY_LAST) begin
                    state_d = (core_busy_q == {NUM_CORES{1'b0}}) ? S_DONE_FAIL : S_RUN;
                end else begin
                    // Lowest idle core wins; cores freed this cycle wait until next cycle.
                    for (int i = 0; i < NUM_CORES; i++) begin
                        if (!core_busy_q[i] && !disp_s) begin
                            disp_s                               = 1'b1;
                            core_busy_d[i]                       = 1'b1;
                            core_start_d[i]                      = 1'b1;
                            core_key_d[i*KEY_WIDTH +: KEY_WIDTH] = next_key_q[KEY_WIDTH-1:0];
                            next_key_d                           = next_key_q + CNT_ONE;
                        end else begin
                            disp_s = disp_s;
                        end
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d      = (state_d == S_RUN) || (state_d == S_DRAIN);
        found_d     = (state_d == S_DONE_FOUND);
        not_found_d = (state_d == S_DONE_FAIL);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            next_key_q   <= {CNT_W{1'b0}};
            core_busy_q  <= {NUM_CORES{1'b0}};
            core_start_q <= {NUM_CORES{1'b0}};
            core_key_q   <= {(NUM_CORES*KEY_WIDTH){1'b0}};
            found_key_q  <= {KEY_WIDTH{1'b0}};
            keys_tried_q <= {CNT_W{1'b0}};
            busy_q       <= 1'b0;
            found_q      <= 1'b0;
            not_found_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            next_key_q   <= next_key_d;
            core_busy_q  <= core_busy_d;
            core_start_q <= core_start_d;
            core_key_q   <= core_key_d;
            found_key_q  <= found_key_d;
            keys_tried_q <= keys_tried_d;
            busy_q       <= busy_d;
            found_q      <= found_d;
            not_found_q  <= not_found_d;
        end
    end

    assign bus.core_start = core_start_q;
    assign bus.core_key   = core_key_q;
    assign bus.found_key  = found_key_q;
    assign bus.keys_tried = keys_tried_q;
    assign bus.busy       = busy_q;
    assign bus.found      = found_q;
    assign bus.not_found  = not_found_q;
endmodule

// File: tb/tb_rc4_core_scheduler.sv
// Directed + randomized bench: behavioural cores with configurable latency feed the scheduler,
// and a key-level model (dispatch log, finish count, valid-key map) supplies every expectation.
module tb_rc4_core_scheduler;
    localparam int NC    = 4;
    localparam int KW    = 6;
    localparam int NKEYS = 64;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    rc4_core_scheduler_if #(.NUM_CORES(NC), .KEY_WIDTH(KW)) bus ();

    rc4_core_scheduler #(
        .NUM_CORES(NC),
        .KEY_WIDTH(KW),
        .KEY_MAX  (6'h3F)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Stimulus knobs, written only by the main initial block.
    bit          valid_map [NKEYS];
    bit          rand_lat  = 1'b0;
    int          fixed_lat = 10;
    bit          manual    = 1'b0;
    logic [NC-1:0] man_fin  = 4'b0000;
    logic [NC-1:0] spur_fin = 4'b0000;
    int          epoch     = 0;

    // Core model state, written only by the core model process.
    int          seen_epoch  = 0;
    logic [NC-1:0] active    = 4'b0000;
    int          cnt  [NC];
    int          hkey [NC];
    int          disp_q[$];
    int          disp_core_q[$];
    int          fin_cnt     = 0;
    bit          valid_seen  = 1'b0;
    int          late_starts = 0;
    int          bad_starts  = 0;

    // Behavioural cores: launch on core_start, finish after a latency or on command.
    always @(negedge clk) begin
        logic [NC-1:0] fin;
        logic [NC-1:0] val;
        bit            hit;
        fin = 4'b0000;
        val = NC'($urandom);
        hit = 1'b0;
        if (epoch != seen_epoch) begin
            seen_epoch = epoch;
            disp_q.delete();
            disp_core_q.delete();
            fin_cnt     = 0;
            valid_seen  = 1'b0;
            late_starts = 0;
            bad_starts  = 0;
        end
        if (!reset_n) begin
            active = 4'b0000;
        end else begin
            if ($countones(bus.core_start) > 1) bad_starts++;
            for (int i = 0; i < NC; i++) begin
                if (bus.core_start[i]) begin
                    if (active[i]) bad_starts++;
                    if (valid_seen) late_starts++;
                    active[i] = 1'b1;
                    hkey[i]   = int'(bus.core_key[i*KW +: KW]);
                    cnt[i]    = rand_lat ? int'($urandom_range(40, 5)) : fixed_lat;
                    disp_q.push_back(hkey[i]);
                    disp_core_q.push_back(i);
                end else if (active[i]) begin
                    if (manual) begin
                        fin[i] = man_fin[i];
                    end else begin
                        cnt[i]--;
                        fin[i] = (cnt[i] == 0);
                    end
                    if (fin[i]) begin
                        active[i] = 1'b0;
                        val[i]    = valid_map[hkey[i]];
                        fin_cnt++;
                        hit = hit | val[i];
                    end
                end else begin
                    fin[i] = spur_fin[i];
                end
            end
            if (hit) valid_seen = 1'b1;
        end
        bus.core_finish = fin;
        bus.core_valid  = val;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        epoch++;
        bus.start = 1'b1;
        @(negedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit spur_en);
        int n;
        n = 0;
        while (!(bus.found || bus.not_found) && n < budget) begin
            spur_fin = (spur_en && $urandom_range(7, 0) == 0) ? NC'($urandom) : 4'b0000;
            @(negedge clk); #1;
            n++;
        end
        spur_fin = 4'b0000;
        chk("done_in_time", 64'(n < budget), 64'd1);
    endtask

    task automatic wait_disp(input int count, input int budget);
        int n;
        n = 0;
        while (disp_q.size() < count && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        chk("dispatch_in_time", 64'(n < budget), 64'd1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_core_start"}, 64'(bus.core_start), 64'd0);
        chk({tag, "_core_key"},   64'(bus.core_key),   64'd0);
        chk({tag, "_busy"},       64'(bus.busy),       64'd0);
        chk({tag, "_found"},      64'(bus.found),      64'd0);
        chk({tag, "_not_found"},  64'(bus.not_found),  64'd0);
        chk({tag, "_found_key"},  64'(bus.found_key),  64'd0);
        chk({tag, "_keys_tried"}, 64'(bus.keys_tried), 64'd0);
    endtask

    task automatic end_checks(input string tag, input bit exp_found, input int exp_key,
                              input int exp_tried);
        chk({tag, "_found"},      64'(bus.found),      64'(exp_found));
        chk({tag, "_not_found"},  64'(bus.not_found),  64'(!exp_found));
        chk({tag, "_found_key"},  64'(bus.found_key),  64'(exp_key));
        chk({tag, "_busy"},       64'(bus.busy),       64'd0);
        chk({tag, "_tried_vs_model"}, 64'(bus.keys_tried), 64'(fin_cnt));
        chk({tag, "_disp_vs_fin"}, 64'(disp_q.size()), 64'(fin_cnt));
        if (exp_tried >= 0) chk({tag, "_keys_tried"}, 64'(bus.keys_tried), 64'(exp_tried));
        chk({tag, "_in_flight"},   64'(active),        64'd0);
        chk({tag, "_late_starts"}, 64'(late_starts),   64'd0);
        chk({tag, "_bad_starts"},  64'(bad_starts),    64'd0);
        for (int j = 0; j < disp_q.size(); j++) begin
            chk({tag, "_key_order"}, 64'(disp_q[j]), 64'(j));
        end
    endtask

    initial begin
        bus.start = 1'b0;
        for (int k = 0; k < NKEYS; k++) valid_map[k] = 1'b0;

        // Power-on reset.
        repeat (3) @(negedge clk);
        #1;
        chk_zero("reset");
        reset_n = 1'b1;
        @(negedge clk); #1;
        chk("idle_busy", 64'(bus.busy), 64'd0);

        // Hit on key 9 with fixed 10-cycle cores; a start during RUN must be ignored.
        valid_map[9] = 1'b1;
        fixed_lat    = 10;
        pulse_start();
        chk("k9_busy_after_start", 64'(bus.busy), 64'd1);
        chk("k9_no_early_start",   64'(bus.core_start), 64'd0);
        @(negedge clk); #1;
        chk("k9_first_start", 64'(bus.core_start), 64'd1);
        chk("k9_first_key",   64'(bus.core_key[KW-1:0]), 64'd0);
        repeat (4) @(negedge clk);
        #1;
        bus.start = 1'b1;
        @(negedge clk); #1;
        bus.start = 1'b0;
        wait_done(400, 1'b0);
        end_checks("k9", 1'b1, 9, 12);

        // Restart from DONE_FOUND; exhaustive search with no valid key and spurious finishes.
        valid_map[9] = 1'b0;
        fixed_lat    = 5;
        pulse_start();
        chk("restart_found",      64'(bus.found),      64'd0);
        chk("restart_keys_tried", 64'(bus.keys_tried), 64'd0);
        chk("restart_found_key",  64'(bus.found_key),  64'd0);
        chk("restart_busy",       64'(bus.busy),       64'd1);
        wait_done(1000, 1'b1);
        end_checks("fail", 1'b0, 0, 64);

        // Only the last key is valid.
        valid_map[63] = 1'b1;
        fixed_lat     = 3;
        pulse_start();
        wait_done(1000, 1'b1);
        end_checks("last", 1'b1, 63, 64);
        valid_map[63] = 1'b0;

        // Simultaneous valid finishes on core 1 (key 5) and core 3 (key 7).
        manual       = 1'b1;
        valid_map[5] = 1'b1;
        valid_map[7] = 1'b1;
        pulse_start();
        wait_disp(4, 20);
        man_fin = 4'b1111;
        @(negedge clk); #1;
        man_fin = 4'b0000;
        wait_disp(8, 20);
        chk("simul_key5_core", 64'(disp_core_q[5]), 64'd1);
        chk("simul_key7_core", 64'(disp_core_q[7]), 64'd3);
        man_fin = 4'b1111;
        @(negedge clk); #1;
        man_fin = 4'b0000;
        wait_done(20, 1'b0);
        end_checks("simul", 1'b1, 5, 8);
        manual       = 1'b0;
        valid_map[5] = 1'b0;
        valid_map[7] = 1'b0;

        // Reset in the middle of a random-latency search.
        rand_lat = 1'b1;
        pulse_start();
        repeat (30) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk_zero("async_reset");
        @(negedge clk); #1;
        chk_zero("held_reset");
        reset_n = 1'b1;

        // Fresh random-latency search, valid on key 40, with spurious finishes.
        valid_map[40] = 1'b1;
        pulse_start();
        wait_disp(1, 10);
        chk("post_reset_core", 64'(disp_core_q[0]), 64'd0);
        chk("post_reset_key",  64'(disp_q[0]),      64'd0);
        wait_done(4000, 1'b1);
        end_checks("rand", 1'b1, 40, -1);
        chk("rand_reached_40", 64'(disp_q.size() > 40), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/rc4_core_scheduler.md
Name: rc4_core_scheduler

Overview:
- Dispatches candidate RC4 secret keys to NUM_CORES parallel cracking cores. Each core is an init/shuffle/compute pipeline with its own S, E and D memories.
- Hands out keys in ascending order, one per start pulse, and collects per-core pass/fail results.
- Stops issuing keys on the first valid-ASCII result, drains in-flight cores, then reports the winning key.
- Replaces the single-core main FSM key sweep at the multi-core top level.

Parameters:
- NUM_CORES, 4, number of cracking cores (1..16).
- KEY_WIDTH, 24, secret key width in bits.
- KEY_MAX, 24'h3FFFFF, last key in the search space (inclusive).

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- start  input  1  single-cycle pulse; begins a search from key 0
- core_start  output  NUM_CORES  one-cycle pulse per core; launches that core on core_key
- core_key  output  NUM_CORES*KEY_WIDTH  key for core i in slice [i*KEY_WIDTH +: KEY_WIDTH]; held stable while core i is busy
- core_finish  input  NUM_CORES  one-cycle pulse from core i when its decryption completes
- core_valid  input  NUM_CORES  sampled only with core_finish[i]; 1 = all decrypted bytes valid ASCII
- busy  output  1  high from the cycle after start is accepted until a DONE state is reached
- found  output  1  high in DONE_FOUND
- not_found  output  1  high in DONE_FAIL
- found_key  output  KEY_WIDTH  winning key; valid while found=1
- keys_tried  output  KEY_WIDTH+1  count of core_finish events accepted in the current search

Behaviour:
- Reset (asynchronous, immediate):
  - All outputs 0.
  - State IDLE; next_key=0; per-core busy flags cleared.
  - Reset mid-search abandons the search; cores are reset by the same reset_n.
- States:
  - IDLE: waits for start. start=1 clears found_key, keys_tried and next_key, then goes to RUN.
  - RUN: dispatch and collect.
    - If a valid result is accepted, go to DRAIN.
    - Otherwise, if next_key>KEY_MAX and no core is busy, go to DONE_FAIL.
  - DRAIN: no dispatch. Wait until all busy flags clear, then go to DONE_FOUND.
  - DONE_FOUND / DONE_FAIL: hold results. start=1 restarts exactly as from IDLE.
- start in RUN or DRAIN is ignored.
- Dispatch, RUN only:
  - At most one core_start per cycle.
  - Target is the lowest-index core that is not busy, provided next_key<=KEY_MAX.
  - The same edge registers core_key[i]=next_key, sets busy[i] and increments next_key.
  - The core_start pulse appears in the cycle after that edge, so the first core_start[0] with key 0 arrives 1 cycle after start is sampled.
  - No dispatch in the same cycle the search transitions to DRAIN.
- Collection, every cycle in RUN/DRAIN:
  - For each i with core_finish[i] and busy[i]: clear busy[i] and increment keys_tried.
  - A freed core is eligible for dispatch in the next cycle, not the same cycle.
  - core_finish from a non-busy core is ignored: no count, no state effect.
- Found:
  - The first accepted finish with core_valid=1 in RUN latches found_key=core_key[i].
  - Simultaneous valid finishes: lowest core index wins.
  - Valid results arriving in DRAIN are counted but do not change found_key.
- Boundaries:
  - KEY_MAX reached: next_key stops at KEY_MAX+1. No key is dispatched twice and none is skipped.
  - The key counter is KEY_WIDTH+1 bits, so KEY_MAX=all-ones does not wrap.
  - Valid result on key KEY_MAX gives DONE_FOUND, not DONE_FAIL.
- Invariant: core_key[i] changes only on a dispatch edge for core i.

Test Plan:
- Search hits key 9:
  - Setup: NUM_CORES=4, KEY_MAX=15, cores model a fixed 10-cycle latency, valid only for key 9.
  - Required: found=1, found_key=9, no core_start after the valid finish, busy drops only after cores holding keys 10..11 finish.
- Exhaustive fail:
  - Setup: KEY_MAX=7, no valid key.
  - Required: each key 0..7 dispatched exactly once, not_found=1, keys_tried=8, found_key=0.
- Simultaneous valid finishes:
  - Setup: core 1 (key 5) and core 3 (key 7) both pulse finish with valid in the same cycle.
  - Required: found_key=5.
- Mid-search reset:
  - Setup: reset_n low for 1 cycle during RUN.
  - Required: all outputs 0 asynchronously; a subsequent start dispatches key 0 to core 0.
- start handling:
  - start pulsed during RUN is ignored: key sequence uninterrupted.
  - start in DONE_FOUND clears found and keys_tried, and restarts at key 0.
- Random core latencies (5..40 cycles), NUM_CORES=4, KEY_MAX=63, valid on key 40:
  - Required: found_key=40, keys dispatched strictly ascending, spurious core_finish on an idle core does not change keys_tried.
